s2a_capture_seq: RTL and testbench
==================================

Name: s2a_capture_seq

Overview:
- Stream-side sequencer for the S2A stream-to-OCM writer, in the Sclk domain.
- Arms a capture on command and emits the writer's sync pulse.
- Discards a programmable number of settling samples, then gates sample strobes into the writer's buffer-write enable (Ien).
- Captures only whole 16-sample blocks, so the AXI side never sees a partial burst.
- Reports progress (block count, state) and completion to the control/register layer.

Parameters:
CNT_W, 32, width of block-count target and block counter
BLK_LEN, 16, samples per block; must equal the S2A burst length (power of two)
SYNC_LEN, 4, cycles sync is held high (>=1)
TIMEOUT_CYC, 1024, watchdog limit in Sclk cycles; used only with S2A_SEQ_TIMEOUT_EN

Ports:
Sclk  in  1  stream clock
rst  in  1  reset, synchronous, active-high
cfg_start  in  1  one-cycle pulse: arm and start capture
cfg_stop  in  1  one-cycle pulse: stop capture at next block boundary
cfg_nblk  in  CNT_W  blocks to capture; 0 = continuous until stop
cfg_skip  in  16  valid samples to discard after sync
din_valid  in  1  sample strobe from ADC interface
sync  out  1  reset/sync to S2A writer
Ien  out  1  buffer write enable to S2A writer
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  sticky; capture abandoned before RUN, or watchdog fired
blk_cnt  out  CNT_W  completed blocks in current/last capture
state  out  3  current state encoding, for status readback

Behaviour:
- Reset (rst high at a Sclk edge), from any state including mid-capture:
  - state=IDLE.
  - sync, Ien, done, busy, aborted = 0; blk_cnt = 0.
- All outputs are registered.
- Ien is din_valid delayed by 1 cycle and gated by state. The sample datapath must delay data by one register to stay aligned.
- States and encodings: IDLE=0, SYNC=1, SKIP=2, RUN=3, DRAIN=4, DONE=5.
- IDLE:
  - cfg_start -> SYNC; clear blk_cnt, sample counter and aborted; latch cfg_nblk and cfg_skip.
  - cfg_start and cfg_stop in the same cycle: stop wins, start ignored, stay IDLE.
- SYNC:
  - sync=1 for exactly SYNC_LEN cycles, first cycle being the cycle after cfg_start.
  - Then -> SKIP, or -> RUN directly if latched skip==0.
  - din_valid is ignored during SYNC.
- SKIP:
  - Count din_valid; Ien stays 0.
  - On the skip-th valid sample -> RUN; the next valid is the first captured sample.
- cfg_stop in SYNC or SKIP: -> IDLE next cycle; sync=0; aborted=1; no done pulse.
- RUN:
  - Each din_valid produces Ien=1 on the next cycle and increments the sample counter mod BLK_LEN.
  - On the valid that wraps the counter (BLK_LEN-1 -> 0), blk_cnt increments; the new value is visible 1 cycle later.
  - If latched nblk!=0 and the incremented blk_cnt equals nblk -> DONE.
- cfg_stop in RUN:
  - Sample counter==0 (on a boundary, no valid this cycle) -> DONE immediately.
  - Otherwise -> DRAIN.
  - If stop coincides with the wrapping valid, that block completes and counts, then -> DONE.
- DRAIN: behaves as RUN but ignores further cfg_stop. -> DONE on the next block wrap.
- DONE: done=1 for one cycle, Ien=0, -> IDLE.
- cfg_start while busy: ignored.
- blk_cnt wraps modulo 2^CNT_W in continuous mode.
- blk_cnt holds its value in IDLE until the next start.
- Ien never asserts outside RUN/DRAIN. Ien count is always a multiple of BLK_LEN per capture.

Optional Feature:
Macro S2A_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in SKIP, RUN and DRAIN. It clears on each din_valid and increments otherwise.
  - Reaching TIMEOUT_CYC forces IDLE next cycle and sets aborted=1. No done pulse; the partial block is discarded (no further Ien).
- Not defined: no watchdog logic; the sequencer waits indefinitely for samples.

Test Plan:
- nblk=2, skip=3, din_valid every cycle, start -> sync high 4 cycles; first 3 valids dropped; exactly 32 Ien cycles; blk_cnt=2; done pulse one cycle after last Ien; busy falls.
- nblk=0, din_valid every 2nd cycle, stop after 20 Ien -> drains to 32 Ien total; blk_cnt=2; done=1; aborted=0.
- Stop issued on the same cycle as the 16th valid -> blk_cnt=1, 16 Ien total, done, no DRAIN entry; stop in SKIP -> IDLE, aborted=1, no Ien, no done.
- start+stop same cycle in IDLE -> stays IDLE, sync never asserts; start while RUN -> ignored, blk_cnt unaffected; rst asserted mid-RUN -> all outputs 0 next cycle.
- S2A_SEQ_TIMEOUT_EN with TIMEOUT_CYC=8: din_valid stops after 5 captured samples -> IDLE after 8 idle cycles, aborted=1, Ien stays 0, no done; without macro, stays in RUN.

Source files
------------

// File: rtl/s2a_capture_seq.sv
// Stream-side capture sequencer for the S2A writer: sync pulse, settling-sample skip, whole-block Ien gating.
// Optional watchdog is compiled in with `define S2A_SEQ_TIMEOUT_EN.
module s2a_capture_seq #(
   parameter int CNT_W       = 32,
   parameter int BLK_LEN     = 16,
   parameter int SYNC_LEN    = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             Sclk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_stop,
   input  logic [CNT_W-1:0] cfg_nblk,
   input  logic [15:0]      cfg_skip,
   input  logic             din_valid,
   output logic             sync,
   output logic             Ien,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] blk_cnt,
   output logic [2:0]       state
);

   localparam int SMP_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
   localparam int SYNC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
   localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(BLK_LEN - 1);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_SKIP  = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              sync_q, ien_q, busy_q, done_q;
   logic              ien_d;
   logic              aborted_q, aborted_d;
   logic [CNT_W-1:0]  blk_q, blk_d, blk_inc;
   logic [CNT_W-1:0]  nblk_q, nblk_d;
   logic [15:0]       skip_q, skip_d;
   logic [15:0]       skip_cnt_q, skip_cnt_d;
   logic [SMP_W-1:0]  smp_q, smp_d;
   logic [SYNC_W-1:0] syn_cnt_q, syn_cnt_d;
   // fin_q: the closing block has just wrapped; its last Ien is on the wire, DONE follows
   logic              fin_q, fin_d;
`ifdef S2A_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);
   logic [WD_W-1:0]   wd_q, wd_d;
`endif

   // Next-state and datapath decode for the capture sequence
   always_comb begin
      state_d    = state_q;
      aborted_d  = aborted_q;
      blk_d      = blk_q;
      nblk_d     = nblk_q;
      skip_d     = skip_q;
      skip_cnt_d = skip_cnt_q;
      smp_d      = smp_q;
      syn_cnt_d  = syn_cnt_q;
      fin_d      = 1'b0;
      ien_d      = 1'b0;
      blk_inc    = blk_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            if (cfg_start && !cfg_stop) begin
               state_d    = S_SYNC;
               blk_d      = {CNT_W{1'b0}};
               smp_d      = {SMP_W{1'b0}};
               skip_cnt_d = 16'd0;
               syn_cnt_d  = {SYNC_W{1'b0}};
               aborted_d  = 1'b0;
               nblk_d     = cfg_nblk;
               skip_d     = cfg_skip;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SYNC: begin
            if (cfg_stop) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (syn_cnt_q == SYNC_LAST) begin
               state_d = (skip_q == 16'd0) ? S_RUN : S_SKIP;
            end else begin
               syn_cnt_d = syn_cnt_q + SYNC_W'(1);
            end
         end
         S_SKIP: begin
            if (cfg_stop) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (din_valid) begin
               if ((skip_cnt_q + 16'd1) == skip_q) begin
                  state_d = S_RUN;
               end else begin
                  skip_cnt_d = skip_cnt_q + 16'd1;
               end
            end else begin
               state_d = S_SKIP;
            end
         end
         S_RUN, S_DRAIN: begin
            if (fin_q) begin
               state_d = S_DONE;
            end else if (din_valid) begin
               ien_d = 1'b1;
               smp_d = smp_q + SMP_W'(1);
               if (smp_q == SMP_LAST) begin
                  blk_d = blk_inc;
                  // A stop landing on the wrapping sample still counts that block
                  if (((nblk_q != {CNT_W{1'b0}}) && (blk_inc == nblk_q)) ||
                      (cfg_stop && (state_q == S_RUN)) || (state_q == S_DRAIN)) begin
                     fin_d = 1'b1;
                  end else begin
                     fin_d = 1'b0;
                  end
               end else if (cfg_stop && (state_q == S_RUN)) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = state_q;
               end
            end else if (cfg_stop && (state_q == S_RUN)) begin
               state_d = (smp_q == {SMP_W{1'b0}}) ? S_DONE : S_DRAIN;
            end else begin
               state_d = state_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef S2A_SEQ_TIMEOUT_EN
      wd_d = {WD_W{1'b0}};
      if ((state_q == S_SKIP) || (state_q == S_RUN) || (state_q == S_DRAIN)) begin
         if (din_valid) begin
            wd_d = {WD_W{1'b0}};
         end else if ((wd_q + WD_W'(1)) == WD_LIM) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            fin_d     = 1'b0;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end else begin
         wd_d = {WD_W{1'b0}};
      end
`endif
   end

   // State, counters and registered outputs
   always_ff @(posedge Sclk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= 1'b0;
         ien_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         blk_q      <= {CNT_W{1'b0}};
         nblk_q     <= {CNT_W{1'b0}};
         skip_q     <= 16'd0;
         skip_cnt_q <= 16'd0;
         smp_q      <= {SMP_W{1'b0}};
         syn_cnt_q  <= {SYNC_W{1'b0}};
         fin_q      <= 1'b0;
`ifdef S2A_SEQ_TIMEOUT_EN
         wd_q       <= {WD_W{1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         sync_q     <= (state_d == S_SYNC);
         ien_q      <= ien_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
         aborted_q  <= aborted_d;
         blk_q      <= blk_d;
         nblk_q     <= nblk_d;
         skip_q     <= skip_d;
         skip_cnt_q <= skip_cnt_d;
         smp_q      <= smp_d;
         syn_cnt_q  <= syn_cnt_d;
         fin_q      <= fin_d;
`ifdef S2A_SEQ_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   assign sync    = sync_q;
   assign Ien     = ien_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign blk_cnt = blk_q;
   assign state   = state_q;

endmodule

// File: tb/tb_s2a_capture_seq.sv
// Directed bench for s2a_capture_seq: per-capture expectations queued at start, checked when the capture ends.
module tb_s2a_capture_seq;

   localparam int CNT_W = 32;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_SYNC = 3'd1, ST_SKIP = 3'd2,
                          ST_RUN = 3'd3, ST_DRAIN = 3'd4, ST_DONE = 3'd5;

   logic             Sclk = 1'b0;
   logic             rst, cfg_start, cfg_stop, din_valid;
   logic [CNT_W-1:0] cfg_nblk;
   logic [15:0]      cfg_skip;
   logic             sync, Ien, busy, done, aborted;
   logic [CNT_W-1:0] blk_cnt;
   logic [2:0]       state;

   s2a_capture_seq #(.CNT_W(CNT_W), .BLK_LEN(16), .SYNC_LEN(4), .TIMEOUT_CYC(8)) dut (
      .Sclk(Sclk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_nblk(cfg_nblk), .cfg_skip(cfg_skip), .din_valid(din_valid),
      .sync(sync), .Ien(Ien), .busy(busy), .done(done), .aborted(aborted),
      .blk_cnt(blk_cnt), .state(state));

   always #5 Sclk = ~Sclk;

   // Output monitor, sampled on the falling edge
   int cyc = 0, ien_tot = 0, done_tot = 0, sync_tot = 0, last_ien = -1, last_done = -1;
   always @(negedge Sclk) begin
      cyc <= cyc + 1;
      if (Ien)  begin ien_tot  <= ien_tot + 1;  last_ien  <= cyc; end
      if (done) begin done_tot <= done_tot + 1; last_done <= cyc; end
      if (sync) sync_tot <= sync_tot + 1;
   end

   typedef struct {
      string tag;
      int    ien;
      int    blk;
      int    dn;
      int    ab;
      int    sy;
   } exp_t;
   exp_t sb[$];
   int b_ien, b_done, b_sync;
   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge Sclk);
      #1;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s);
      int k = 0;
      while (state !== s && k < 200) begin step(); k++; end
      chk(tag, 64'(state), 64'(s));
   endtask

   task automatic launch(input string tag, input int nblk, input int skip,
                         input int e_ien, input int e_blk, input int e_dn, input int e_ab, input int e_sy);
      exp_t e;
      e.tag = tag; e.ien = e_ien; e.blk = e_blk; e.dn = e_dn; e.ab = e_ab; e.sy = e_sy;
      sb.push_back(e);
      b_ien = ien_tot; b_done = done_tot; b_sync = sync_tot;
      cfg_nblk  = CNT_W'(nblk);
      cfg_skip  = 16'(skip);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic finish_cap();
      exp_t e;
      int k = 0;
      while (busy !== 1'b0 && k < 1000) begin step(); k++; end
      step();
      e = sb.pop_front();
      chk({e.tag, " busy"},    64'(busy), 64'd0);
      chk({e.tag, " ien"},     64'(ien_tot - b_ien), 64'(e.ien));
      chk({e.tag, " blk_cnt"}, 64'(blk_cnt), 64'(e.blk));
      chk({e.tag, " done"},    64'(done_tot - b_done), 64'(e.dn));
      chk({e.tag, " aborted"}, 64'(aborted), 64'(e.ab));
      chk({e.tag, " sync"},    64'(sync_tot - b_sync), 64'(e.sy));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int  k;
      bit  sent;
      rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; din_valid = 1'b0;
      cfg_nblk = '0; cfg_skip = 16'd0;
      repeat (3) step();
      chk("rst state", 64'(state), 64'(ST_IDLE));
      chk("rst sync", 64'(sync), 64'd0);
      chk("rst Ien", 64'(Ien), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst aborted", 64'(aborted), 64'd0);
      chk("rst blk_cnt", 64'(blk_cnt), 64'd0);
      rst = 1'b0;
      step();

      // 1: nblk=2, skip=3, valid every cycle
      din_valid = 1'b1;
      launch("t1", 2, 3, 32, 2, 1, 0, 4);
      chk("t1 sync c1", 64'(sync), 64'd1);
      chk("t1 state c1", 64'(state), 64'(ST_SYNC));
      chk("t1 busy c1", 64'(busy), 64'd1);
      repeat (3) step();
      chk("t1 sync c4", 64'(sync), 64'd1);
      step();
      chk("t1 sync c5", 64'(sync), 64'd0);
      chk("t1 state c5", 64'(state), 64'(ST_SKIP));
      repeat (2) step();
      chk("t1 state c7", 64'(state), 64'(ST_SKIP));
      step();
      chk("t1 state c8", 64'(state), 64'(ST_RUN));
      chk("t1 Ien c8", 64'(Ien), 64'd0);
      step();
      chk("t1 Ien c9", 64'(Ien), 64'd1);
      finish_cap();
      chk("t1 done after last Ien", 64'(last_done - last_ien), 64'd1);
      din_valid = 1'b0;
      step();

      // 2: continuous, valid every 2nd cycle, stop after 20 Ien, drain to 32
      launch("t2", 0, 0, 32, 2, 1, 0, 4);
      k = 0; sent = 1'b0;
      while (busy === 1'b1 && k < 400) begin
         din_valid = k[0];
         cfg_stop  = (!sent && (ien_tot - b_ien) >= 20);
         step();
         k++;
         if (cfg_stop) begin
            sent = 1'b1;
            cfg_stop = 1'b0;
            chk("t2 drain entry", 64'(state), 64'(ST_DRAIN));
         end
      end
      din_valid = 1'b0;
      chk("t2 stop sent", 64'(sent), 64'd1);
      finish_cap();

      // 3a: stop on the 16th valid: block counts, no drain, later valids ignored
      din_valid = 1'b1;
      launch("t3a", 0, 0, 16, 1, 1, 0, 4);
      wait_state("t3a run", ST_RUN);
      repeat (15) step();
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      chk("t3a state after stop", 64'(state), 64'(ST_RUN));
      chk("t3a blk_cnt after stop", 64'(blk_cnt), 64'd1);
      step();
      chk("t3a state done", 64'(state), 64'(ST_DONE));
      chk("t3a done pulse", 64'(done), 64'd1);
      chk("t3a Ien in done", 64'(Ien), 64'd0);
      finish_cap();
      din_valid = 1'b0;

      // 3b: stop during SKIP aborts
      launch("t3b", 1, 5, 0, 0, 0, 1, 4);
      wait_state("t3b skip", ST_SKIP);
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      chk("t3b state", 64'(state), 64'(ST_IDLE));
      chk("t3b aborted", 64'(aborted), 64'd1);
      finish_cap();

      // 4a: start+stop together in IDLE is ignored
      cfg_start = 1'b1; cfg_stop = 1'b1;
      step();
      cfg_start = 1'b0; cfg_stop = 1'b0;
      chk("t4a state", 64'(state), 64'(ST_IDLE));
      step();
      chk("t4a sync", 64'(sync), 64'd0);
      chk("t4a busy", 64'(busy), 64'd0);
      chk("t4a aborted kept", 64'(aborted), 64'd1);

      // 4b: start while running is ignored
      din_valid = 1'b1;
      launch("t4b", 2, 0, 32, 2, 1, 0, 4);
      wait_state("t4b run", ST_RUN);
      repeat (5) step();
      cfg_nblk  = CNT_W'(7);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("t4b state", 64'(state), 64'(ST_RUN));
      chk("t4b blk_cnt", 64'(blk_cnt), 64'd0);
      finish_cap();

      // 4c: reset mid-RUN clears every output
      cfg_nblk = '0; cfg_skip = 16'd0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      wait_state("t4c run", ST_RUN);
      repeat (20) step();
      chk("t4c blk_cnt pre", 64'(blk_cnt), 64'd1);
      chk("t4c Ien pre", 64'(Ien), 64'd1);
      rst = 1'b1;
      step();
      chk("t4c state", 64'(state), 64'(ST_IDLE));
      chk("t4c Ien", 64'(Ien), 64'd0);
      chk("t4c busy", 64'(busy), 64'd0);
      chk("t4c blk_cnt", 64'(blk_cnt), 64'd0);
      chk("t4c sync/done/aborted", 64'({sync, done, aborted}), 64'd0);
      rst = 1'b0;
      din_valid = 1'b0;
      step();

      // 5: samples stop after 5 captured
      din_valid = 1'b1;
      launch("t5", 0, 0, 5, 0, 0, 1, 4);
      wait_state("t5 run", ST_RUN);
      repeat (5) step();
      din_valid = 1'b0;
      repeat (7) step();
      chk("t5 state after 7 idle", 64'(state), 64'(ST_RUN));
      step();
`ifdef S2A_SEQ_TIMEOUT_EN
      chk("t5 state timeout", 64'(state), 64'(ST_IDLE));
      chk("t5 aborted", 64'(aborted), 64'd1);
      finish_cap();
`else
      chk("t5 state no watchdog", 64'(state), 64'(ST_RUN));
      repeat (12) step();
      chk("t5 still run", 64'(state), 64'(ST_RUN));
      chk("t5 Ien count", 64'(ien_tot - b_ien), 64'd5);
      chk("t5 no done", 64'(done_tot - b_done), 64'd0);
      void'(sb.pop_front());
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
